// File: rtl/afpm_operand_loader.sv
// afpm_operand_loader: byte-serial FP16 operand assembler for the logarithmic
// multiplier. Two beats per pair (low byte, then high byte). Lane 0 carries
// operand A and lane 1 carries operand B. Assembled operands are classified and
// handed to the core over valid/ready.

// Per-lane FP16 class decode. The three flags are mutually exclusive.
module afpm_classify #(
  parameter bit FTZ = 1'b1
) (
  input  logic [15:0] op,
  output logic        zero,
  output logic        inf,
  output logic        nan
);
  logic [4:0] exp_f;
  logic [9:0] man_f;

  assign exp_f = op[14:10];
  assign man_f = op[9:0];
  // Subnormals count as zero only when flushing is enabled.
  assign zero  = (exp_f == 5'd0) && (FTZ || (man_f == 10'd0));
  assign inf   = (exp_f == 5'h1f) && (man_f == 10'd0);
  assign nan   = (exp_f == 5'h1f) && (man_f != 10'd0);
endmodule

module afpm_operand_loader #(
  parameter int TIMEOUT_CYC = 15,
  parameter int CNT_W       = 4,
  parameter int FTZ         = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       in_valid,
  input  logic [7:0] a_byte,
  input  logic [7:0] b_byte,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [15:0] op_a,
  output logic [15:0] op_b,
  output logic       a_zero,
  output logic       a_inf,
  output logic       a_nan,
  output logic       b_zero,
  output logic       b_inf,
  output logic       b_nan,
  output logic       busy,
  output logic       timeout_pulse,
  output logic       overrun_pulse
);
  localparam int NUM_LANES = 2;
  // Counter value at which a stalled half-pair is discarded.
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HAVE_LO = 2'd1,
    S_FULL    = 2'd2
  } state_t;

  state_t                              state_q, state_d;
  logic [CNT_W-1:0]                    cnt_q, cnt_d;
  logic [NUM_LANES-1:0][7:0]           in_byte, lo_q;
  logic [NUM_LANES-1:0][15:0]          op_q, op_nxt;
  logic [NUM_LANES-1:0][2:0]           flg_q, flg_nxt;  // {nan, inf, zero}
  logic                                load_lo, load_hi;
  logic                                tmo_d, ovr_d, tmo_q, ovr_q;

  assign in_byte = {b_byte, a_byte};

  // Per-lane assembly of the candidate operand and its class flags, so the
  // flags are registered in the same edge as the operand itself.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign op_nxt[i] = {in_byte[i], lo_q[i]};
    afpm_classify #(.FTZ(FTZ != 0)) u_cls (
      .op   (op_nxt[i]),
      .zero (flg_nxt[i][0]),
      .inf  (flg_nxt[i][1]),
      .nan  (flg_nxt[i][2])
    );
  end

  // State, counter and data registers; ena=0 freezes everything but the pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      lo_q    <= '0;
      op_q    <= '0;
      flg_q   <= '0;
      tmo_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else if (ena) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load_lo)    lo_q <= in_byte;
      else if (tmo_d) lo_q <= '0;
      if (load_hi) begin
        op_q  <= op_nxt;
        flg_q <= flg_nxt;
      end
      tmo_q <= tmo_d;
      ovr_q <= ovr_d;
    end else begin
      tmo_q <= 1'b0;
      ovr_q <= 1'b0;
    end
  end

  // Next-state: beat sequencing, timeout and handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load_lo = 1'b0;
    load_hi = 1'b0;
    tmo_d   = 1'b0;
    ovr_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          load_lo = 1'b1;
          cnt_d   = '0;
          state_d = S_HAVE_LO;
        end
      end
      S_HAVE_LO: begin
        // A high beat wins over a timeout expiring in the same cycle.
        if (in_valid) begin
          load_hi = 1'b1;
          state_d = S_FULL;
        end else if (TIMEOUT_CYC > 0) begin
          if (cnt_q == TMO_LAST) begin
            tmo_d   = 1'b1;
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_FULL: begin
        if (out_ready) begin
          // Transfer completes; a simultaneous beat starts the next pair.
          if (in_valid) begin
            load_lo = 1'b1;
            cnt_d   = '0;
            state_d = S_HAVE_LO;
          end else begin
            state_d = S_IDLE;
          end
        end else if (in_valid) begin
          ovr_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: status decoded from state, pulses suppressed while disabled.
  always_comb begin
    out_valid     = (state_q == S_FULL);
    busy          = (state_q != S_IDLE);
    timeout_pulse = tmo_q & ena;
    overrun_pulse = ovr_q & ena;
    op_a          = op_q[0];
    op_b          = op_q[1];
    a_zero        = flg_q[0][0];
    a_inf         = flg_q[0][1];
    a_nan         = flg_q[0][2];
    b_zero        = flg_q[1][0];
    b_inf         = flg_q[1][1];
    b_nan         = flg_q[1][2];
  end
endmodule

// File: tb/tb_afpm_operand_loader.sv
// Directed bench for afpm_operand_loader with a pair scoreboard. A second
// instance with FTZ=0 shares the stimulus to check subnormal classification.
module tb_afpm_operand_loader;
  logic clk = 1'b0;
  logic rst_n, ena, in_valid, out_ready;
  logic [7:0] a_byte, b_byte;

  logic out_valid, a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  logic busy, timeout_pulse, overrun_pulse;
  logic [15:0] op_a, op_b;

  logic z_out_valid, z_a_zero, z_a_inf, z_a_nan, z_b_zero, z_b_inf, z_b_nan;
  logic z_busy, z_timeout_pulse, z_overrun_pulse;
  logic [15:0] z_op_a, z_op_b;

  afpm_operand_loader dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid),
    .a_byte(a_byte), .b_byte(b_byte), .out_valid(out_valid),
    .out_ready(out_ready), .op_a(op_a), .op_b(op_b),
    .a_zero(a_zero), .a_inf(a_inf), .a_nan(a_nan),
    .b_zero(b_zero), .b_inf(b_inf), .b_nan(b_nan),
    .busy(busy), .timeout_pulse(timeout_pulse), .overrun_pulse(overrun_pulse)
  );

  afpm_operand_loader #(.FTZ(0)) dut_noftz (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid),
    .a_byte(a_byte), .b_byte(b_byte), .out_valid(z_out_valid),
    .out_ready(out_ready), .op_a(z_op_a), .op_b(z_op_b),
    .a_zero(z_a_zero), .a_inf(z_a_inf), .a_nan(z_a_nan),
    .b_zero(z_b_zero), .b_inf(z_b_inf), .b_nan(z_b_nan),
    .busy(z_busy), .timeout_pulse(z_timeout_pulse), .overrun_pulse(z_overrun_pulse)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [5:0]  f;   // {b_nan,b_inf,b_zero,a_nan,a_inf,a_zero}
  } exp_t;

  exp_t sb[$];
  int nchk = 0;
  int nerr = 0;

  // Reference classifier: {nan, inf, zero}.
  function automatic logic [2:0] cls(input logic [15:0] v, input bit ftz);
    logic [4:0] e;
    logic [9:0] m;
    e = v[14:10];
    m = v[9:0];
    return {(e == 5'd31) && (m != 0), (e == 5'd31) && (m == 0), (e == 5'd0) && (ftz || m == 0)};
  endfunction

  function automatic logic [5:0] flags_obs();
    return {b_nan, b_inf, b_zero, a_nan, a_inf, a_zero};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    nchk++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] a, input logic [7:0] b);
    in_valid = 1'b1;
    a_byte   = a;
    b_byte   = b;
    tick();
    in_valid = 1'b0;
  endtask

  // Low beat, push the expected result, then the high beat.
  task automatic pair(input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    beat(a[7:0], b[7:0]);
    e.a = a;
    e.b = b;
    e.f = {cls(b, 1'b1), cls(a, 1'b1)};
    sb.push_back(e);
    beat(a[15:8], b[15:8]);
  endtask

  task automatic check_pair(input string tag);
    exp_t e;
    chk({tag, "_out_valid"}, out_valid, 1);
    chk({tag, "_sb_size"}, sb.size(), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_op_a"}, op_a, e.a);
      chk({tag, "_op_b"}, op_b, e.b);
      chk({tag, "_flags"}, flags_obs(), e.f);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a_byte = 8'h00; b_byte = 8'h00;
    #2;
    chk("rst_outputs",
        {out_valid, op_a, op_b, flags_obs(), busy, timeout_pulse, overrun_pulse}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle_busy", busy, 0);

    // 1: basic pair, one-cycle latency after the high beat
    out_ready = 1'b1;
    beat(8'h00, 8'h00);
    chk("t1_busy_lo", busy, 1);
    chk("t1_valid_lo", out_valid, 0);
    sb.push_back('{a: 16'h3E00, b: 16'h4200, f: 6'd0});
    beat(8'h3E, 8'h42);
    check_pair("t1");
    tick();
    chk("t1_valid_fall", out_valid, 0);
    chk("t1_busy_idle", busy, 0);
    chk("t1_op_a_held", op_a, 16'h3E00);

    // 2: zeros, and subnormal vs FTZ
    pair(16'h0000, 16'h0000);
    chk("t2_zero_flags", flags_obs(), 6'b001_001);
    check_pair("t2z");
    tick();
    pair(16'h0001, 16'h8000);
    check_pair("t2s");
    chk("t2_ftz0_op_a", z_op_a, 16'h0001);
    chk("t2_ftz0_flags", {z_b_nan, z_b_inf, z_b_zero, z_a_nan, z_a_inf, z_a_zero},
        {cls(16'h8000, 1'b0), cls(16'h0001, 1'b0)});
    chk("t2_ftz0_a_zero", z_a_zero, 0);
    tick();

    // 3: inf/nan, backpressure hold and overrun
    out_ready = 1'b0;
    pair(16'h7C00, 16'h7E01);
    check_pair("t3");
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        beat(8'h55, 8'h66);
        chk("t3_overrun", overrun_pulse, 1);
      end else begin
        tick();
        chk("t3_no_overrun", overrun_pulse, 0);
      end
      chk("t3_hold_valid", out_valid, 1);
      chk("t3_hold_op_a", op_a, 16'h7C00);
      chk("t3_hold_op_b", op_b, 16'h7E01);
      chk("t3_hold_flags", flags_obs(), 6'b100_010);
    end
    out_ready = 1'b1;
    tick();
    chk("t3_done", out_valid, 0);

    // 4: timeout after 15 idle cycles, then byte order preserved
    beat(8'hAA, 8'hBB);
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k < 15) begin
        chk("t4_no_tmo", timeout_pulse, 0);
        chk("t4_busy", busy, 1);
      end else begin
        chk("t4_tmo", timeout_pulse, 1);
        chk("t4_busy_clr", busy, 0);
      end
    end
    tick();
    chk("t4_tmo_one_cycle", timeout_pulse, 0);
    pair(16'hC000, 16'h3C00);
    check_pair("t4");
    tick();

    // 5: new low beat accepted in the handshake cycle
    out_ready = 1'b0;
    pair(16'h0301, 16'h0402);
    check_pair("t5a");
    out_ready = 1'b1;
    beat(8'h11, 8'h22);
    chk("t5_valid_after_hs", out_valid, 0);
    chk("t5_busy_lo", busy, 1);
    sb.push_back('{a: 16'h3311, b: 16'h4422, f: {cls(16'h4422, 1'b1), cls(16'h3311, 1'b1)}});
    beat(8'h33, 8'h44);
    check_pair("t5b");
    tick();

    // 6: ena=0 freezes HAVE_LO (no timeout, beats ignored); async reset in FULL
    out_ready = 1'b0;
    beat(8'h12, 8'h34);
    ena = 1'b0;
    for (int i = 0; i < 30; i++) begin
      in_valid = (i < 5);
      a_byte   = 8'hEE;
      b_byte   = 8'hEE;
      tick();
      chk("t6_no_tmo", timeout_pulse, 0);
      chk("t6_frozen_valid", out_valid, 0);
    end
    in_valid = 1'b0;
    ena = 1'b1;
    chk("t6_still_busy", busy, 1);
    sb.push_back('{a: 16'h5612, b: 16'h7834, f: {cls(16'h7834, 1'b1), cls(16'h5612, 1'b1)}});
    beat(8'h56, 8'h78);
    check_pair("t6");
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_rst",
        {out_valid, op_a, op_b, flags_obs(), busy, timeout_pulse, overrun_pulse}, 64'd0);
    #1;
    rst_n = 1'b1;
    tick();
    chk("t6_post_rst_idle", busy, 0);
    chk("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
